// File: rtl/pkt_xmtr_if.sv
// Byte-input / serial-output bundle of the packet transmitter.
interface pkt_xmtr_if;
  logic [7:0] DIN;
  logic       VALID;
  logic       RDY;
  logic       SDATA;
  logic       BUSY;
  logic       TX_DONE;

  modport master (output DIN, VALID, input RDY, SDATA, BUSY, TX_DONE);
  modport slave  (input DIN, VALID, output RDY, SDATA, BUSY, TX_DONE);
endinterface

// File: rtl/pkt_xmtr.sv
// Serial packet transmitter: collects BODY_SIZE/8 bytes, shifts
// {HEADER_VALUE, body} out MSB-first, then idles SDATA low for GAP_BITS.
module pkt_xmtr #(
  parameter int                     HEADER_SIZE  = 8,
  parameter logic [HEADER_SIZE-1:0] HEADER_VALUE = 8'ha5,
  parameter int                     BODY_SIZE    = 16,
  parameter int                     GAP_BITS     = 8
) (
  input  logic      SCLK,
  input  logic      RST,
  pkt_xmtr_if.slave bus
);
  localparam int NB    = BODY_SIZE / 8;
  localparam int FRAME = HEADER_SIZE + BODY_SIZE;
  localparam int BCW   = $clog2(FRAME + 1);
  localparam int GCW   = $clog2(GAP_BITS + 1);
  localparam int NCW   = $clog2(NB + 1);

  typedef enum logic [1:0] {COLLECT, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [FRAME-1:0] shreg, shreg_n;
  logic [BCW-1:0]   bitcnt, bitcnt_n;
  logic [GCW-1:0]   gapcnt, gapcnt_n;
  logic [NCW-1:0]   bytecnt, bytecnt_n;
  logic             sdata_q, sdata_n;
  logic             rdy_q, rdy_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  // Bytes accumulate in the low end of the shift register while collecting;
  // on the last byte the header is merged on top to form the whole frame.
  logic [FRAME-1:0] body_acc, frame_ld;
  assign body_acc = {shreg[FRAME-9:0], bus.DIN};
  assign frame_ld = {HEADER_VALUE, {BODY_SIZE{1'b0}}}
                  | (body_acc & {{HEADER_SIZE{1'b0}}, {BODY_SIZE{1'b1}}});

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    gapcnt_n  = gapcnt;
    bytecnt_n = bytecnt;
    sdata_n   = 1'b0;
    rdy_n     = rdy_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    case (state)
      COLLECT: begin
        rdy_n  = 1'b1;
        busy_n = 1'b0;
        if (bus.VALID && rdy_q) begin
          if (bytecnt == NCW'(NB - 1)) begin
            state_n   = SEND;
            sdata_n   = frame_ld[FRAME-1];
            shreg_n   = {frame_ld[FRAME-2:0], 1'b0};
            bitcnt_n  = BCW'(1);
            bytecnt_n = '0;
            rdy_n     = 1'b0;
            busy_n    = 1'b1;
          end else begin
            shreg_n   = body_acc;
            bytecnt_n = bytecnt + 1'b1;
          end
        end
      end
      SEND: begin
        // bitcnt is the number of frame bits already put on SDATA
        if (bitcnt == BCW'(FRAME)) begin
          state_n  = GAP;
          done_n   = 1'b1;
          gapcnt_n = GCW'(1);
        end else begin
          sdata_n  = shreg[FRAME-1];
          shreg_n  = {shreg[FRAME-2:0], 1'b0};
          bitcnt_n = bitcnt + 1'b1;
        end
      end
      GAP: begin
        if (gapcnt == GCW'(GAP_BITS)) begin
          state_n   = COLLECT;
          rdy_n     = 1'b1;
          busy_n    = 1'b0;
          bytecnt_n = '0;
        end else begin
          gapcnt_n = gapcnt + 1'b1;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // State and output registers; reset aborts any frame and forces SDATA low.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state   <= COLLECT;
      shreg   <= '0;
      bitcnt  <= '0;
      gapcnt  <= '0;
      bytecnt <= '0;
      sdata_q <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bitcnt  <= bitcnt_n;
      gapcnt  <= gapcnt_n;
      bytecnt <= bytecnt_n;
      sdata_q <= sdata_n;
      rdy_q   <= rdy_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.SDATA   = sdata_q;
  assign bus.RDY     = rdy_q;
  assign bus.BUSY    = busy_q;
  assign bus.TX_DONE = done_q;
endmodule

// File: tb/tb_pkt_xmtr.sv
// Randomized scoreboard bench for pkt_xmtr plus a directed check of a
// small-parameter instance.
module tb_pkt_xmtr;
  localparam int         HS = 8, BS = 16, GB = 8, FR = HS + BS;
  localparam logic [7:0] HV = 8'ha5;

  logic SCLK = 1'b0;
  logic RST  = 1'b1;
  int   total = 0, bad = 0;

  always #5 SCLK = ~SCLK;

  pkt_xmtr_if ifa ();
  pkt_xmtr_if ifb ();

  pkt_xmtr #(.HEADER_SIZE(HS), .HEADER_VALUE(HV), .BODY_SIZE(BS), .GAP_BITS(GB))
    dut (.SCLK(SCLK), .RST(RST), .bus(ifa.slave));

  pkt_xmtr #(.HEADER_SIZE(4), .HEADER_VALUE(4'h9), .BODY_SIZE(8), .GAP_BITS(3))
    dut2 (.SCLK(SCLK), .RST(RST), .bus(ifb.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: one expected frame per complete packet offered.
  logic [FR-1:0] expq[$];
  int            frames = 0;

  // Monitor: reassembles frames from SDATA and checks framing/gap/handshake.
  int            mph = 0;
  int            bi  = 0;
  logic [FR-1:0] fr;
  logic          prev_acc = 1'b0;
  always @(negedge SCLK) begin
    if (RST) begin
      mph = 0;
    end else begin
      case (mph)
        0: begin
          chk("idle_done", ifa.TX_DONE, 1'b0);
          if (ifa.BUSY) begin
            chk("latency", prev_acc, 1'b1);
            chk("frame_ctl", {ifa.RDY, ifa.TX_DONE}, 2'b00);
            fr = '0;
            fr[FR-1] = ifa.SDATA;
            bi = 1;
            mph = 1;
          end
        end
        1: begin
          chk("frame_ctl", {ifa.BUSY, ifa.RDY, ifa.TX_DONE}, 3'b100);
          fr[FR-1-bi] = ifa.SDATA;
          bi++;
          if (bi == FR) begin
            if (expq.size() == 0) chk("unexpected_frame", fr, '0);
            else                  chk("frame", fr, expq.pop_front());
            frames++;
            bi = 0;
            mph = 2;
          end
        end
        2: begin
          chk("gap", {ifa.SDATA, ifa.BUSY, ifa.RDY, ifa.TX_DONE}, {3'b010, bi == 0});
          bi++;
          if (bi == GB) mph = 3;
        end
        default: begin
          chk("post_gap", {ifa.BUSY, ifa.RDY, ifa.TX_DONE}, 3'b010);
          mph = 0;
        end
      endcase
    end
    prev_acc = ifa.VALID && ifa.RDY;
  end

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   n;
    repeat (gap) begin
      ifa.VALID = 1'b0;
      ifa.DIN   = 8'($urandom);
      @(posedge SCLK); #1;
    end
    ifa.VALID = 1'b1;
    ifa.DIN   = b;
    n = 0;
    do begin
      @(negedge SCLK);
      acc = ifa.RDY;
      @(posedge SCLK); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge SCLK); #3;
    RST = 1'b1;
    #1;
    chk("abort_outputs", {ifa.SDATA, ifa.RDY, ifa.BUSY, ifa.TX_DONE}, 4'b0000);
    repeat (cycles) @(posedge SCLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    logic [7:0]  b0, b1;
    logic [11:0] v;
    int          n;
    ifa.VALID = 1'b0; ifa.DIN = 8'h00;
    ifb.VALID = 1'b0; ifb.DIN = 8'h00;

    // reset values, then RDY one edge after release
    repeat (3) @(posedge SCLK);
    @(negedge SCLK);
    chk("rst_a", {ifa.SDATA, ifa.RDY, ifa.BUSY, ifa.TX_DONE}, 4'b0000);
    chk("rst_b", {ifb.SDATA, ifb.RDY, ifb.BUSY, ifb.TX_DONE}, 4'b0000);
    @(posedge SCLK); #1 RST = 1'b0;
    @(negedge SCLK);
    chk("rdy_before_edge", ifa.RDY, 1'b0);
    @(negedge SCLK);
    chk("rdy_after_edge", ifa.RDY, 1'b1);
    @(posedge SCLK); #1;

    // directed packet
    expq.push_back({HV, 16'h1234});
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    ifa.VALID = 1'b0;

    // VALID held high, DIN advancing only when consumed
    expq.push_back({HV, 16'h0001});
    expq.push_back({HV, 16'h0203});
    expq.push_back({HV, 16'h0405});
    for (int i = 0; i < 6; i++) send_byte(8'(i), 0);
    ifa.VALID = 1'b0;

    // abort mid-frame, then discard a partial packet
    send_byte(8'hab, 2);
    send_byte(8'hcd, 0);
    ifa.VALID = 1'b0;
    repeat (9) @(posedge SCLK);
    pulse_reset(2);
    send_byte(8'h77, 3);
    ifa.VALID = 1'b0;
    pulse_reset(1);
    expq.push_back({HV, 16'hff00});
    send_byte(8'hff, 1);
    send_byte(8'h00, 0);
    ifa.VALID = 1'b0;

    // random packets with random inter-byte idle
    for (int p = 0; p < 4; p++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      expq.push_back({HV, b0, b1});
      send_byte(b0, int'($urandom_range(8, 0)));
      send_byte(b1, int'($urandom_range(8, 0)));
    end
    ifa.VALID = 1'b0;

    n = 0;
    while ((expq.size() != 0 || mph != 0) && n < 1000) begin
      @(posedge SCLK);
      n++;
    end
    #1;
    chk("drain", 32'(expq.size()), 32'd0);
    chk("frame_count", 32'(frames), 32'd9);

    // small-parameter instance: header 4'h9, body 8'hC3, gap 3
    @(negedge SCLK);
    chk("b_rdy", ifb.RDY, 1'b1);
    @(posedge SCLK); #1;
    ifb.VALID = 1'b1; ifb.DIN = 8'hc3;
    @(posedge SCLK); #1;
    ifb.VALID = 1'b0; ifb.DIN = 8'h5a;
    for (int i = 0; i < 12; i++) begin
      @(negedge SCLK);
      v[11-i] = ifb.SDATA;
    end
    chk("b_frame", v, 12'h9c3);
    for (int i = 0; i < 3; i++) begin
      @(negedge SCLK);
      chk("b_gap", {ifb.SDATA, ifb.BUSY, ifb.RDY, ifb.TX_DONE}, {3'b010, i == 0});
    end
    @(negedge SCLK);
    chk("b_post", {ifb.SDATA, ifb.BUSY, ifb.RDY, ifb.TX_DONE}, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pkt_xmtr.md
Name: pkt_xmtr

Overview:
- Serial packet transmitter that sits directly upstream of the serial receiver (rcvr) and drives its SDATA input.
- Accepts body bytes over a VALID/RDY byte handshake and buffers one packet body.
- Serialises header plus body MSB-first, one bit per SCLK cycle, then holds SDATA low for a fixed inter-packet gap.
- Uses the same HEADER_SIZE/HEADER_VALUE/BODY_SIZE parameter set as the receiver, so the two connect back-to-back.

Parameters:
HEADER_SIZE, 8, header width in bits (1..32)
HEADER_VALUE, 8'ha5, header pattern sent before each body; width HEADER_SIZE
BODY_SIZE, 16, body width in bits; multiple of 8, range 8..64
GAP_BITS, 8, number of SDATA=0 cycles after each frame (>=1)

Ports:
SCLK  in  1  clock, rising-edge active
RST  in  1  asynchronous active-high reset
DIN  in  8  body byte; first accepted byte is the most significant body byte
VALID  in  1  DIN holds a valid byte
RDY  out  1  block can accept a byte this cycle
SDATA  out  1  serial output to rcvr SDATA, registered
BUSY  out  1  frame or gap in progress
TX_DONE  out  1  one-cycle pulse after the last frame bit has been driven

Behaviour:
- Reset (async, RST=1):
  - State = COLLECT; byte count = 0; shift register and bit counter cleared.
  - Outputs: SDATA=0, RDY=0, BUSY=0, TX_DONE=0.
  - RDY rises on the first SCLK edge after RST deasserts.
- All outputs are registered and update on the rising edge of SCLK only.
- States are COLLECT, SEND and GAP. NB = BODY_SIZE/8. FRAME = HEADER_SIZE+BODY_SIZE.
- COLLECT:
  - RDY=1.
  - A byte is accepted on an edge where VALID&&RDY; accepted bytes fill the body buffer MSB-first.
  - VALID with RDY=0 is ignored. DIN is don't-care when VALID=0.
  - On the edge that accepts byte NB: state->SEND; shift register <= {HEADER_VALUE, body}; SDATA <= frame bit FRAME-1 (header MSB); RDY<=0; BUSY<=1.
  - First header bit therefore appears the cycle after the last byte is accepted (latency 1).
- SEND:
  - Each edge shifts left; SDATA <= next bit.
  - Each frame bit is held for exactly one cycle, with no gaps or repeats; total SDATA window is FRAME cycles.
  - On the edge after the last (LSB) body bit's cycle: state->GAP; SDATA<=0; TX_DONE<=1 for exactly one cycle.
- GAP:
  - SDATA=0 for GAP_BITS cycles, counted from the cycle TX_DONE is high.
  - Then state->COLLECT; RDY<=1; BUSY<=0; byte count = 0.
- Frame-to-frame minimum period: NB accept cycles + FRAME + GAP_BITS.
- RDY never asserts while BUSY=1.
- RST asserted mid-frame or mid-gap: the frame is aborted immediately and SDATA=0 asynchronously. Partially collected bytes are discarded; no TX_DONE.
- VALID held high continuously: exactly NB bytes are accepted per frame, one per cycle while RDY=1. No byte is lost or duplicated across the COLLECT->SEND boundary.
- Counters: the bit counter is sized clog2(FRAME+1) and the gap counter clog2(GAP_BITS+1). Neither counter wraps.

Test Plan:
1. Defaults; after reset, send 8'h12 then 8'h34 on consecutive cycles -> SDATA = 1010_0101_0001_0010_0011_0100 starting the cycle after the 8'h34 accept. Then 8 cycles of 0, TX_DONE pulse once, RDY low for exactly 32 cycles.
2. Reset values: RST held high -> SDATA=0, RDY=0, BUSY=0, TX_DONE=0. RDY=1 one edge after release.
3. VALID held high with DIN incrementing 8'h00,8'h01,... for 3 frames -> frame bodies are 16'h0001, 16'h0203, 16'h0405. Bytes presented while RDY=0 are not consumed.
4. Assert RST at bit 10 of a frame -> SDATA=0 immediately and no TX_DONE. A new packet 8'hFF,8'h00 afterwards sends a clean 24-bit frame.
5. Parameters HEADER_SIZE=4, HEADER_VALUE=4'h9, BODY_SIZE=8, GAP_BITS=3; send 8'hC3 -> SDATA = 1001_1100_0011 followed by 000.
6. Loopback into rcvr with defaults: 4 packets of seeded random bytes, receiver acknowledges with random 0-8 cycle delays -> all 8 received DOUT bytes equal the sent bytes, in order.
